// File: rtl/letc_core_pkg.sv
// Core-wide types and constants shared by the LETC core pipeline blocks.
// Register index and data word types live here with the rest of the core
// definitions.
package letc_core_pkg;

    // Architectural register index (x0..x31) and data word.
    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    // Source that owns the integer register-file write port in a given cycle.
    typedef enum logic [1:0] {
        RF_WSRC_NONE = 2'd0,
        RF_WSRC_W    = 2'd1,
        RF_WSRC_LLU  = 2'd2
    } rf_wsrc_e;

    // Writeback wins this many buffered-LLU contention cycles in a row before
    // the arbiter forces a writeback stall.
    localparam int unsigned LLU_MAX_DEFER_DEFAULT = 4;

endpackage : letc_core_pkg

// File: rtl/letc_core_rf_wport_arbiter.sv
// Register-file write port arbiter.
// The in-order writeback stage normally owns the single RF write port. Results
// from the long-latency unit are parked in a 1-entry buffer and written when
// writeback is idle. If writeback keeps the port busy for MAX_DEFER cycles in a
// row, a one-cycle writeback stall is requested so the buffer can drain.
// The buffered result is exposed to the forwarder until it is written.
module letc_core_rf_wport_arbiter
    import letc_core_pkg::*;
#(
    parameter int unsigned MAX_DEFER = LLU_MAX_DEFER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        w_rd_we,
    input  logic [4:0]  w_rd_idx,
    input  logic [31:0] w_rd_val,

    input  logic        llu_valid,
    output logic        llu_ready,
    input  logic [4:0]  llu_rd_idx,
    input  logic [31:0] llu_rd_val,

    output logic        w_stall_req,

    output logic        rf_rd_we,
    output logic [4:0]  rf_rd_idx,
    output logic [31:0] rf_rd_val,

    output logic        fwd_valid,
    output logic [4:0]  fwd_rd_idx,
    output logic [31:0] fwd_rd_val
);

    localparam int unsigned CNT_W = $clog2(MAX_DEFER + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DEFER);

    // Holding buffer and starvation counter.
    logic             r_buf_valid;
    reg_idx_t         r_buf_idx;
    word_t            r_buf_val;
    logic [CNT_W-1:0] r_defer_cnt;

    logic     w_llu_accept;
    rf_wsrc_e w_grant;

    // Handshake and forced-stall request; both derive only from registers and
    // LLU inputs, never from the writeback request.
    always_comb begin
        llu_ready    = !r_buf_valid;
        w_llu_accept = llu_valid && !r_buf_valid;
        w_stall_req  = r_buf_valid && (r_defer_cnt == CNT_MAX);
    end

    // Port grant by priority, then steer the selected source onto the RF port.
    always_comb begin
        // NOTE: every output of this block is assigned a default first, so no
        // path through the case leaves a signal unassigned and infers a latch.
        w_grant   = RF_WSRC_NONE;
        rf_rd_we  = 1'b0;
        rf_rd_idx = '0;
        rf_rd_val = '0;

        if (w_stall_req) begin
            w_grant = RF_WSRC_LLU;
        end else if (w_rd_we) begin
            w_grant = RF_WSRC_W;
        end else if (r_buf_valid) begin
            w_grant = RF_WSRC_LLU;
        end

        case (w_grant)
            RF_WSRC_W: begin
                rf_rd_we  = 1'b1;
                rf_rd_idx = w_rd_idx;
                rf_rd_val = w_rd_val;
            end
            RF_WSRC_LLU: begin
                rf_rd_we  = 1'b1;
                rf_rd_idx = r_buf_idx;
                rf_rd_val = r_buf_val;
            end
            default: ;
        endcase
    end

    // The buffer is presented to the forwarder for as long as it is valid,
    // including the cycle it is being written.
    always_comb begin
        fwd_valid  = r_buf_valid;
        fwd_rd_idx = r_buf_idx;
        fwd_rd_val = r_buf_val;
    end

    // Buffer: drain on grant, load on handshake. The two never coincide since
    // the LLU is only accepted while the buffer is empty. Results for x0 are
    // accepted but dropped.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_idx   <= '0;
            r_buf_val   <= '0;
        end else if (w_grant == RF_WSRC_LLU) begin
            r_buf_valid <= 1'b0;
        end else if (w_llu_accept && (llu_rd_idx != '0)) begin
            r_buf_valid <= 1'b1;
            r_buf_idx   <= llu_rd_idx;
            r_buf_val   <= llu_rd_val;
        end
    end

    // Starvation counter: counts writeback wins against a waiting entry,
    // saturating at MAX_DEFER, and clears once the entry drains or is absent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_defer_cnt <= '0;
        end else if (!r_buf_valid || (w_grant == RF_WSRC_LLU)) begin
            r_defer_cnt <= '0;
        end else if ((w_grant == RF_WSRC_W) && (r_defer_cnt != CNT_MAX)) begin
            r_defer_cnt <= r_defer_cnt + CNT_W'(1);
        end
    end

    // Interface invariants expected from the hazard unit, scoreboard and LLU.
    a_no_stall_with_we : assert property (@(posedge clk) disable iff (rst)
        !(w_stall_req && w_rd_we));

    a_no_waw : assert property (@(posedge clk) disable iff (rst)
        !(r_buf_valid && w_rd_we && (w_rd_idx == r_buf_idx) && (w_rd_idx != '0)));

    a_llu_stable : assert property (@(posedge clk) disable iff (rst)
        (llu_valid && !llu_ready) |=>
            (llu_valid && $stable(llu_rd_idx) && $stable(llu_rd_val)));

endmodule : letc_core_rf_wport_arbiter

// File: tb/tb_letc_core_rf_wport_arbiter.sv
// Testbench for the RF write port arbiter: a cycle-by-cycle vector table
// covering idle drain, contention, x0 discard with backpressure and a
// mid-operation reset, followed by a hand-written starvation sequence.
module tb_letc_core_rf_wport_arbiter;

    logic        clk;
    logic        rst;
    logic        w_rd_we;
    logic [4:0]  w_rd_idx;
    logic [31:0] w_rd_val;
    logic        llu_valid;
    logic        llu_ready;
    logic [4:0]  llu_rd_idx;
    logic [31:0] llu_rd_val;
    logic        w_stall_req;
    logic        rf_rd_we;
    logic [4:0]  rf_rd_idx;
    logic [31:0] rf_rd_val;
    logic        fwd_valid;
    logic [4:0]  fwd_rd_idx;
    logic [31:0] fwd_rd_val;

    int n_total = 0;
    int n_bad   = 0;

    letc_core_rf_wport_arbiter #(.MAX_DEFER(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .w_rd_we     (w_rd_we),
        .w_rd_idx    (w_rd_idx),
        .w_rd_val    (w_rd_val),
        .llu_valid   (llu_valid),
        .llu_ready   (llu_ready),
        .llu_rd_idx  (llu_rd_idx),
        .llu_rd_val  (llu_rd_val),
        .w_stall_req (w_stall_req),
        .rf_rd_we    (rf_rd_we),
        .rf_rd_idx   (rf_rd_idx),
        .rf_rd_val   (rf_rd_val),
        .fwd_valid   (fwd_valid),
        .fwd_rd_idx  (fwd_rd_idx),
        .fwd_rd_val  (fwd_rd_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected in that same cycle.
    typedef struct {
        logic        rst;
        logic        wwe;
        logic [4:0]  widx;
        logic [31:0] wval;
        logic        lv;
        logic [4:0]  lidx;
        logic [31:0] lval;
        logic        e_ready;
        logic        e_stall;
        logic        e_rfwe;
        logic [4:0]  e_rfidx;
        logic [31:0] e_rfval;
        logic        e_fwdv;
        logic [4:0]  e_fwdidx;
        logic [31:0] e_fwdval;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_row(input int i, input vec_t v);
        string tag;
        tag = $sformatf("row%0d", i);
        check({tag, " llu_ready"},   32'(llu_ready),   32'(v.e_ready));
        check({tag, " w_stall_req"}, 32'(w_stall_req), 32'(v.e_stall));
        check({tag, " rf_rd_we"},    32'(rf_rd_we),    32'(v.e_rfwe));
        check({tag, " rf_rd_idx"},   32'(rf_rd_idx),   32'(v.e_rfidx));
        check({tag, " rf_rd_val"},   rf_rd_val,        v.e_rfval);
        check({tag, " fwd_valid"},   32'(fwd_valid),   32'(v.e_fwdv));
        if (v.e_fwdv) begin
            check({tag, " fwd_rd_idx"}, 32'(fwd_rd_idx), 32'(v.e_fwdidx));
            check({tag, " fwd_rd_val"}, fwd_rd_val,       v.e_fwdval);
        end
        check({tag, " defer_cnt"}, 32'(dut.r_defer_cnt), 32'(v.e_cnt));
    endtask

    initial begin
        rst        = 1'b1;
        w_rd_we    = 1'b0;
        w_rd_idx   = '0;
        w_rd_val   = '0;
        llu_valid  = 1'b0;
        llu_rd_idx = '0;
        llu_rd_val = '0;

        //                 rst wwe widx wval          lv lidx lval          rdy stl rfwe rfidx rfval         fv fidx fval         cnt
        // Reset state, idle port.
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        0, 0,  32'h0,        1,  0,  0,   0,    32'h0,        0, 0,  32'h0,        0});
        // Idle port: accept x5, drain next cycle, empty after.
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        1, 5,  32'h1234,     1,  0,  0,   0,    32'h0,        0, 0,  32'h0,        0});
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        0, 0,  32'h0,        0,  0,  1,   5,    32'h1234,     1, 5,  32'h1234,     0});
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        0, 0,  32'h0,        1,  0,  0,   0,    32'h0,        0, 0,  32'h0,        0});
        // Contention: x7 buffered, writeback writes x3 twice, then x7 drains.
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        1, 7,  32'hAAAA,     1,  0,  0,   0,    32'h0,        0, 0,  32'h0,        0});
        vecs.push_back(vec_t'{0, 1, 3,  32'h1,        0, 0,  32'h0,        0,  0,  1,   3,    32'h1,        1, 7,  32'hAAAA,     0});
        vecs.push_back(vec_t'{0, 1, 3,  32'h1,        0, 0,  32'h0,        0,  0,  1,   3,    32'h1,        1, 7,  32'hAAAA,     1});
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        0, 0,  32'h0,        0,  0,  1,   7,    32'hAAAA,     1, 7,  32'hAAAA,     2});
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        0, 0,  32'h0,        1,  0,  0,   0,    32'h0,        0, 0,  32'h0,        0});
        // Backpressure and x0: x0 accepted and dropped, x4 accepted next,
        // x6 held while x4 waits behind writeback.
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        1, 0,  32'h5555,     1,  0,  0,   0,    32'h0,        0, 0,  32'h0,        0});
        vecs.push_back(vec_t'{0, 1, 3,  32'h2,        1, 4,  32'hBEEF,     1,  0,  1,   3,    32'h2,        0, 0,  32'h0,        0});
        vecs.push_back(vec_t'{0, 1, 3,  32'h3,        1, 6,  32'h6666,     0,  0,  1,   3,    32'h3,        1, 4,  32'hBEEF,     0});
        vecs.push_back(vec_t'{0, 1, 8,  32'h8,        1, 6,  32'h6666,     0,  0,  1,   8,    32'h8,        1, 4,  32'hBEEF,     1});
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        1, 6,  32'h6666,     0,  0,  1,   4,    32'hBEEF,     1, 4,  32'hBEEF,     2});
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        1, 6,  32'h6666,     1,  0,  0,   0,    32'h0,        0, 0,  32'h0,        0});
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        0, 0,  32'h0,        0,  0,  1,   6,    32'h6666,     1, 6,  32'h6666,     0});
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        0, 0,  32'h0,        1,  0,  0,   0,    32'h0,        0, 0,  32'h0,        0});
        // Reset mid-operation: x10 buffered, three writeback wins, then rst.
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        1, 10, 32'hA0A0,     1,  0,  0,   0,    32'h0,        0, 0,  32'h0,        0});
        vecs.push_back(vec_t'{0, 1, 11, 32'h11,       0, 0,  32'h0,        0,  0,  1,   11,   32'h11,       1, 10, 32'hA0A0,     0});
        vecs.push_back(vec_t'{0, 1, 11, 32'h12,       0, 0,  32'h0,        0,  0,  1,   11,   32'h12,       1, 10, 32'hA0A0,     1});
        vecs.push_back(vec_t'{0, 1, 11, 32'h13,       0, 0,  32'h0,        0,  0,  1,   11,   32'h13,       1, 10, 32'hA0A0,     2});
        vecs.push_back(vec_t'{1, 0, 0,  32'h0,        0, 0,  32'h0,        0,  0,  1,   10,   32'hA0A0,     1, 10, 32'hA0A0,     3});
        vecs.push_back(vec_t'{0, 0, 0,  32'h0,        0, 0,  32'h0,        1,  0,  0,   0,    32'h0,        0, 0,  32'h0,        0});

        repeat (2) @(posedge clk);

        // Inputs change on the falling edge; outputs are sampled 1 time unit
        // later, well away from the rising edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            w_rd_we    = vecs[i].wwe;
            w_rd_idx   = vecs[i].widx;
            w_rd_val   = vecs[i].wval;
            llu_valid  = vecs[i].lv;
            llu_rd_idx = vecs[i].lidx;
            llu_rd_val = vecs[i].lval;
            #1;
            check_row(i, vecs[i]);
        end

        // Starvation: writeback wants the port every cycle; the bench plays
        // the hazard unit and drops w_rd_we while w_stall_req is high.
        @(negedge clk);
        rst        = 1'b0;
        w_rd_we    = 1'b0;
        llu_valid  = 1'b1;
        llu_rd_idx = 5'd9;
        llu_rd_val = 32'h9999;
        #1;
        check("starve load llu_ready", 32'(llu_ready), 32'd1);

        begin
            int n_stall;
            n_stall = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                llu_valid  = 1'b0;
                llu_rd_idx = '0;
                llu_rd_val = '0;
                w_rd_we    = !w_stall_req;
                w_rd_idx   = 5'd12;
                w_rd_val   = 32'hC00 + 32'(c);
                #1;
                if (w_stall_req) n_stall++;
                check($sformatf("starve c%0d w_stall_req", c), 32'(w_stall_req), (c == 4) ? 32'd1 : 32'd0);
                check($sformatf("starve c%0d rf_rd_we", c), 32'(rf_rd_we), 32'd1);
                check($sformatf("starve c%0d rf_rd_idx", c), 32'(rf_rd_idx), (c == 4) ? 32'd9 : 32'd12);
                check($sformatf("starve c%0d rf_rd_val", c), rf_rd_val, (c == 4) ? 32'h9999 : 32'hC00 + 32'(c));
                check($sformatf("starve c%0d fwd_valid", c), 32'(fwd_valid), (c <= 4) ? 32'd1 : 32'd0);
                check($sformatf("starve c%0d defer_cnt", c), 32'(dut.r_defer_cnt), (c <= 4) ? 32'(c) : 32'd0);
            end
            check("starve stall cycle count", 32'(n_stall), 32'd1);
        end

        @(negedge clk);
        w_rd_we  = 1'b0;
        w_rd_idx = '0;
        w_rd_val = '0;
        #1;
        check("final rf_rd_we", 32'(rf_rd_we), 32'd0);
        check("final llu_ready", 32'(llu_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_letc_core_rf_wport_arbiter
